// File: rtl/light_pkg.sv
// light_pkg: mode codes shared by the light sequencer blocks.
package light_pkg;
  typedef enum logic [2:0] {
    MODE_OFF      = 3'd0,
    MODE_LEVEL    = 3'd1,
    MODE_CHASE_L  = 3'd2,
    MODE_CHASE_R  = 3'd3,
    MODE_FILL     = 3'd4,
    MODE_BLINK    = 3'd5,
    MODE_PINGPONG = 3'd6,
    MODE_RSVD     = 3'd7
  } mode_t;
endpackage

// File: rtl/light_tick_gen.sv
// light_tick_gen: animation prescaler with a combinational terminal-count step strobe.
module light_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic step
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] r_cnt;
  assign step = en && !clr && (r_cnt == CW'(TICK_DIV - 1));
  always_ff @(posedge clk) begin
    if (rst || clr || step) r_cnt <= '0;
    else if (en) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/light_sequencer.sv
// light_sequencer: clocked light-bar driver with level display and prescaled animations.
module light_sequencer
  import light_pkg::*;
#(
  parameter int N_LIGHTS = 6,
  parameter int TICK_DIV = 50_000_000,
  localparam int LW = $clog2(N_LIGHTS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [2:0]          mode,
  input  logic [LW-1:0]       level,
  output logic [N_LIGHTS-1:0] l,
  output logic                tick
);
  localparam logic [LW-1:0] LAST = LW'(N_LIGHTS - 1);
  localparam logic [LW-1:0] FULL = LW'(N_LIGHTS);
  mode_t r_mode_q, w_mode, w_m;
  logic [LW-1:0] r_pos, w_pos_n;
  logic r_dir, w_dir_n, r_phase, w_phase_n;
  logic w_chg, w_step;
  logic [N_LIGHTS-1:0] w_l_n;
  function automatic logic [N_LIGHTS-1:0] therm(input logic [LW-1:0] k);
    return (k >= FULL) ? '1 : (N_LIGHTS'(1) << k) - N_LIGHTS'(1);
  endfunction
  function automatic logic [N_LIGHTS-1:0] onehot(input logic [LW-1:0] k);
    return N_LIGHTS'(1) << k;
  endfunction
  assign w_mode = mode_t'(mode);
  assign w_chg  = w_mode != r_mode_q;
  assign w_m    = w_chg ? w_mode : r_mode_q;
  light_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (w_chg),
    .step(w_step)
  );
  always_comb begin
    w_pos_n   = r_pos;
    w_dir_n   = r_dir;
    w_phase_n = r_phase;
    if (w_chg) begin
      w_pos_n   = (w_mode == MODE_CHASE_R) ? LAST : '0;
      w_dir_n   = 1'b1;
      w_phase_n = 1'b1;
    end else if (w_step) begin
      case (r_mode_q)
        MODE_CHASE_L: w_pos_n = (r_pos == LAST) ? '0 : r_pos + 1'b1;
        MODE_CHASE_R: w_pos_n = (r_pos == '0) ? LAST : r_pos - 1'b1;
        MODE_FILL:    w_pos_n = (r_pos == FULL) ? '0 : r_pos + 1'b1;
        MODE_BLINK:   w_phase_n = !r_phase;
        MODE_PINGPONG: begin
          // bounce off either end without lingering there for a second step
          w_pos_n = r_dir ? ((r_pos == LAST) ? r_pos - 1'b1 : r_pos + 1'b1)
                          : ((r_pos == '0) ? r_pos + 1'b1 : r_pos - 1'b1);
          w_dir_n = r_dir ? (r_pos != LAST) : (r_pos == '0);
        end
        default: ;
      endcase
    end
    case (w_m)
      MODE_LEVEL:                              w_l_n = therm(level);
      MODE_CHASE_L, MODE_CHASE_R, MODE_PINGPONG: w_l_n = onehot(w_pos_n);
      MODE_FILL:                               w_l_n = therm(w_pos_n);
      MODE_BLINK:                              w_l_n = {N_LIGHTS{w_phase_n}};
      default:                                 w_l_n = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_q <= MODE_OFF;
      r_pos    <= '0;
      r_dir    <= 1'b1;
      r_phase  <= 1'b1;
      l        <= '0;
      tick     <= 1'b0;
    end else begin
      r_mode_q <= w_m;
      r_pos    <= w_pos_n;
      r_dir    <= w_dir_n;
      r_phase  <= w_phase_n;
      tick     <= w_step;
      if (w_chg || en) l <= w_l_n;
    end
  end
endmodule

// File: tb/tb_light_sequencer.sv
// tb_light_sequencer: directed plus random stimulus against a step-count reference model.
module tb_light_sequencer;
  localparam int N = 6;
  localparam int TD = 4;
  localparam int LW = $clog2(N + 1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [LW-1:0] level = '0;
  logic [N-1:0] l;
  logic tick;
  int tests = 0;
  int fails = 0;
  int mq = 0, k = 0, cnt = 0;
  logic [N-1:0] el = '0;
  logic et = 1'b0;
  always #5 clk = ~clk;
  light_sequencer #(.N_LIGHTS(N), .TICK_DIV(TD)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .level(level),
    .l    (l),
    .tick (tick)
  );
  function automatic logic [N-1:0] pat(int m, int s, int lv);
    int p;
    case (m)
      1: return (lv >= N) ? '1 : N'((1 << lv) - 1);
      2: return N'(1 << (s % N));
      3: return N'(1 << (N - 1 - s % N));
      4: return N'((1 << (s % (N + 1))) - 1);
      5: return (s % 2 == 0) ? '1 : '0;
      6: begin
        p = s % (2 * N - 2);
        return N'(1 << ((p < N) ? p : 2 * N - 2 - p));
      end
      default: return '0;
    endcase
  endfunction
  task automatic cyc();
    logic st;
    @(posedge clk);
    if (rst) begin
      mq = 0; k = 0; cnt = 0; el = '0; et = 1'b0;
    end else if (int'(mode) != mq) begin
      mq = int'(mode); k = 0; cnt = 0; et = 1'b0;
      el = pat(mq, k, int'(level));
    end else begin
      st = en && (cnt == TD - 1);
      et = st;
      if (st) begin cnt = 0; k++; end
      else if (en) cnt++;
      if (en) el = pat(mq, k, int'(level));
    end
    #1;
    tests++;
    assert (l === el) else begin
      fails++;
      $error("FAIL l: mode=%0d step=%0d got %b expected %b", mq, k, l, el);
    end
    tests++;
    assert (tick === et) else begin
      fails++;
      $error("FAIL tick: mode=%0d step=%0d got %b expected %b", mq, k, tick, et);
    end
  endtask
  initial begin
    int g;
    repeat (2) cyc();
    rst = 1'b0; en = 1'b1; mode = 3'd2;
    repeat (30) cyc();
    mode = 3'd6;
    repeat (45) cyc();
    mode = 3'd1;
    for (int lv = 0; lv < 8; lv++) begin
      level = LW'(lv);
      cyc(); cyc();
    end
    mode = 3'd4;
    repeat (32) cyc();
    mode = 3'd5;
    cyc();
    g = 0;
    while (cnt != 2 && g < 8) begin cyc(); g++; end
    en = 1'b0;
    repeat (10) cyc();
    en = 1'b1;
    repeat (10) cyc();
    mode = 3'd2;
    repeat (5) cyc();
    g = 0;
    while (cnt != TD - 1 && g < 8) begin cyc(); g++; end
    mode = 3'd3;
    repeat (12) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (8) cyc();
    mode = 3'd1; en = 1'b0; level = LW'(3);
    cyc();
    level = LW'(5);
    repeat (3) cyc();
    en = 1'b1;
    repeat (2) cyc();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) mode = 3'($urandom_range(0, 7));
      en = ($urandom_range(0, 7) != 0);
      level = LW'($urandom_range(0, 7));
      rst = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/light_sequencer.md
# light_sequencer

Parametrised, clocked successor to the team's combinational light decoder. Drives an N-bit light bar from a 3-bit mode code. Supports a static level (thermometer) display plus timed animations (chase, fill, blink, ping-pong) stepped by an internal prescaler. Sits between the mode/selection logic and the LED output pins.

## Interface
- `N_LIGHTS`, default 6: number of lights; must be ≥ 2.
- `TICK_DIV`, default 50_000_000: clock cycles per animation step; must be ≥ 1 (1 = step every cycle).
- `clk` input, 1 bit: single clock, all state on rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `en` input, 1 bit: 1 = prescaler and animation run; 0 = freeze (outputs hold, counter holds).
- `mode` input, 3 bits: pattern select (codes below); sampled every cycle.
- `level` input, `$clog2(N_LIGHTS+1)` bits: lit count for LEVEL mode.
- `l` output, `N_LIGHTS` bits: registered light outputs.
- `tick` output, 1 bit: one-cycle pulse, high in the cycle after an animation step was taken.

## Operation
- Mode codes:
  - 0 OFF: `l` = 0.
  - 1 LEVEL: `l[i]` = 1 for i < `level`; saturates at all-ones when `level` > N_LIGHTS.
  - 2 CHASE_L: single lit bit, starts at bit 0, moves +1 per step, wraps N-1 → 0.
  - 3 CHASE_R: single lit bit, starts at bit N-1, moves −1 per step, wraps 0 → N-1.
  - 4 FILL: lit count starts at 0, +1 per step up to N, then back to 0 (N+1 states).
  - 5 BLINK: starts all-ones, toggles all-ones/all-zero per step.
  - 6 PINGPONG: single bit, starts at bit 0 moving up; reverses at N-1 and at 0; period 2N−2 steps, no repeated end position.
  - 7: reserved; behaves as OFF.
- Internal state: `mode_q`, position/count `pos`, direction `dir`, blink phase, prescaler `cnt`.
- Mode change: when `mode` ≠ `mode_q` on an edge:
  - `mode_q` ← `mode`, `cnt` ← 0, `pos`/`dir`/phase ← initial values.
  - `l` ← the new mode's initial pattern on that same edge.
  - Takes effect regardless of `en`.
- Step: occurs on an edge where `en`=1, no mode change, and `cnt` = TICK_DIV−1. On that edge `cnt` ← 0 and the pattern advances one position. Otherwise, if `en`=1, `cnt` ← `cnt`+1.
- OFF, LEVEL and reserved modes still generate `tick` but the pattern is unaffected by it.
- LEVEL tracks `level` every cycle while `en`=1; `level` is held while `en`=0.
- Simultaneous mode change and step: the mode change wins; no advance and `tick` stays 0.
- `en` low mid-count: `cnt` holds and resumes from the held value; it is not restarted.

## Timing
- Reset: `l` = 0, `tick` = 0, `mode_q` = 0 (OFF), `cnt` = 0, `pos` = 0, `dir` = up, blink phase = on.
- Reset mid-animation: all of the above on the next edge. The first step after reset release occurs TICK_DIV enabled cycles later.
- Latency:
  - `mode` → `l`: 1 clock.
  - `level` → `l` (LEVEL mode): 1 clock.
  - Steps are exactly TICK_DIV enabled cycles apart.
- `tick`: high for exactly 1 cycle, after the step edge, aligned with the updated `l`.
- Widths:
  - `cnt` is `max(1,$clog2(TICK_DIV))` bits.
  - `pos` is `$clog2(N_LIGHTS+1)` bits.
  - All compares are unsigned; no overflow is possible within the stated ranges.

## Structure
- Shared package `light_pkg`: mode code constants (`MODE_OFF` … `MODE_PINGPONG`, `MODE_RSVD`) and the `mode_t` 3-bit type.
- Sub-module `light_tick_gen` (params TICK_DIV): ports `clk`, `rst`, `en`, `clr`, `step`. Holds the prescaler; `clr` = mode change; `step` = combinational terminal-count strobe.
- Top level holds the mode register, the pattern state machine and the output register.

## Test plan
All scenarios use N_LIGHTS=6, TICK_DIV=4.
- Reset, then `en`=1, `mode`=2: `l`=000001 one cycle later; then 000010, 000100, …, 100000, 000001 every 4 cycles; `tick` pulses each step.
- `mode`=6: `l` sequence 000001, 000010, …, 100000, 010000, …, 000001 (period 10 steps).
- `mode`=1, `level` swept 0..7: `l` = 000000, 000001, …, 111111, 111111 with 1-cycle latency; `mode`=4 gives 0, 1, 3, 7, …, 63, 0.
- `mode`=5 with `en` dropped for 10 cycles after 2 counts: `l` holds; the next toggle comes 2 enabled cycles after `en` returns.
- Change `mode` 2→3 on the step edge: `l`=100000 next cycle, `tick`=0, next step 4 cycles later.
- Assert `rst` mid-CHASE_R: `l`=000000, `tick`=0 next cycle; `mode` held at 3 reloads 100000 on the first cycle after release.
